rename_map: RTL and testbench



---
 rtl/rename_map.sv | 222 ++++++++++++++++++++++
 tb/tb_rename_map.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map.sv
// Two-wide register rename stage: allocates destination pregs from the freelist,
// looks up sources in the speculative map, and keeps one map checkpoint per branch tag.
module rename_map #(
    parameter int NUM_AREGS              = 16,
    parameter int NUM_PREGS              = 64,
    parameter int MAX_PREDICT_DEPTH      = 4,
    parameter int MAX_PREDICT_DEPTH_BITS = 3,
    localparam int AB = $clog2(NUM_AREGS),
    localparam int PB = $clog2(NUM_PREGS),
    localparam int TB = MAX_PREDICT_DEPTH_BITS,
    localparam int CB = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_count,
    input  logic [2*AB-1:0]   in_srca,
    input  logic [2*AB-1:0]   in_srcb,
    input  logic [2*AB-1:0]   in_dst,
    input  logic [1:0]        in_has_dst,
    input  logic [2*TB-1:0]   in_spec_tag,
    input  logic              in_ckpt_valid,
    input  logic [TB-1:0]     in_ckpt_tag,
    output logic [1:0]        fl_num_pull,
    output logic [TB-1:0]     fl_branch_tag_1,
    output logic [TB-1:0]     fl_branch_tag_2,
    input  logic [PB-1:0]     fl_preg1,
    input  logic [PB-1:0]     fl_preg2,
    input  logic [PB:0]       fl_num_free,
    input  logic              branch_shootdown,
    input  logic [TB-1:0]     shootdown_branch_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_count,
    output logic [2*PB-1:0]   out_psrca,
    output logic [2*PB-1:0]   out_psrcb,
    output logic [1:0]        out_srca_mapped,
    output logic [1:0]        out_srcb_mapped,
    output logic [2*PB-1:0]   out_pdst,
    output logic [2*PB-1:0]   out_old_pdst,
    output logic [1:0]        out_old_mapped,
    output logic [1:0]        out_has_dst
);

    typedef struct packed {
        logic          mapped;
        logic [PB-1:0] preg;
    } map_entry_t;

    map_entry_t map_q  [NUM_AREGS];
    map_entry_t map_d  [NUM_AREGS];
    map_entry_t ckpt_q [MAX_PREDICT_DEPTH][NUM_AREGS];
    map_entry_t ckpt_d [MAX_PREDICT_DEPTH][NUM_AREGS];

    logic            s1_valid_q, s1_valid_d;
    logic [1:0]      s1_count_q, s1_count_d;
    logic [2*AB-1:0] s1_srca_q, s1_srca_d;
    logic [2*AB-1:0] s1_srcb_q, s1_srcb_d;
    logic [2*AB-1:0] s1_dst_q, s1_dst_d;
    logic [1:0]      s1_has_dst_q, s1_has_dst_d;
    logic            s1_ckpt_valid_q, s1_ckpt_valid_d;
    logic [TB-1:0]   s1_ckpt_tag_q, s1_ckpt_tag_d;

    logic [1:0]    in_dst_live;
    logic [1:0]    need;
    logic          fire;
    logic          accept;
    logic [PB-1:0] pdst0, pdst1;
    map_entry_t    srca0_e, srca1_e, srcb0_e, srcb1_e, old0_e, old1_e;
    logic [AB-1:0] dst0, dst1;
    logic          sd_tag_ok, ck_tag_ok;
    logic [CB-1:0] sd_idx, ck_idx;

    // Stage 0: a slot needs a preg only if it is inside the group and writes a register.
    always_comb begin
        in_dst_live[0]  = (in_count != 2'd0) && in_has_dst[0];
        in_dst_live[1]  = (in_count == 2'd2) && in_has_dst[1];
        need            = {1'b0, in_dst_live[0]} + {1'b0, in_dst_live[1]};
        fire            = s1_valid_q && out_ready;
        in_ready        = !reset && !branch_shootdown && (!s1_valid_q || fire)
                          && (fl_num_free >= (PB+1)'(need));
        accept          = in_valid && in_ready;
        fl_num_pull     = accept ? need : 2'd0;
        fl_branch_tag_1 = '0;
        fl_branch_tag_2 = '0;
        if (accept) begin
            if (in_dst_live[0]) begin
                fl_branch_tag_1 = in_spec_tag[0 +: TB];
                if (in_dst_live[1]) fl_branch_tag_2 = in_spec_tag[TB +: TB];
            end else if (in_dst_live[1]) begin
                fl_branch_tag_1 = in_spec_tag[TB +: TB];
            end
        end
    end

    // Stage 1: slot 1 sees slot 0's fresh destination before the map is written.
    always_comb begin
        dst0    = s1_dst_q[0 +: AB];
        dst1    = s1_dst_q[AB +: AB];
        pdst0   = fl_preg1;
        pdst1   = s1_has_dst_q[0] ? fl_preg2 : fl_preg1;
        srca0_e = map_q[s1_srca_q[0 +: AB]];
        srcb0_e = map_q[s1_srcb_q[0 +: AB]];
        srca1_e = map_q[s1_srca_q[AB +: AB]];
        srcb1_e = map_q[s1_srcb_q[AB +: AB]];
        old0_e  = map_q[dst0];
        old1_e  = map_q[dst1];
        if (s1_has_dst_q[0] && s1_srca_q[AB +: AB] == dst0) srca1_e = '{mapped: 1'b1, preg: pdst0};
        if (s1_has_dst_q[0] && s1_srcb_q[AB +: AB] == dst0) srcb1_e = '{mapped: 1'b1, preg: pdst0};
        if (s1_has_dst_q[0] && dst1 == dst0)                old1_e  = '{mapped: 1'b1, preg: pdst0};
    end

    always_comb begin
        out_valid       = s1_valid_q;
        out_count       = '0;
        out_psrca       = '0;
        out_psrcb       = '0;
        out_srca_mapped = '0;
        out_srcb_mapped = '0;
        out_pdst        = '0;
        out_old_pdst    = '0;
        out_old_mapped  = '0;
        out_has_dst     = '0;
        if (s1_valid_q) begin
            out_count          = s1_count_q;
            out_psrca[0 +: PB] = srca0_e.preg;
            out_psrcb[0 +: PB] = srcb0_e.preg;
            out_srca_mapped[0] = srca0_e.mapped;
            out_srcb_mapped[0] = srcb0_e.mapped;
            out_has_dst[0]     = s1_has_dst_q[0];
            if (s1_has_dst_q[0]) begin
                out_pdst[0 +: PB]     = pdst0;
                out_old_pdst[0 +: PB] = old0_e.preg;
                out_old_mapped[0]     = old0_e.mapped;
            end
            if (s1_count_q == 2'd2) begin
                out_psrca[PB +: PB] = srca1_e.preg;
                out_psrcb[PB +: PB] = srcb1_e.preg;
                out_srca_mapped[1]  = srca1_e.mapped;
                out_srcb_mapped[1]  = srcb1_e.mapped;
                out_has_dst[1]      = s1_has_dst_q[1];
                if (s1_has_dst_q[1]) begin
                    out_pdst[PB +: PB]     = pdst1;
                    out_old_pdst[PB +: PB] = old1_e.preg;
                    out_old_mapped[1]      = old1_e.mapped;
                end
            end
        end
    end

    // Shootdown overrides any commit of the squashed group, including its checkpoint write.
    always_comb begin
        sd_tag_ok = (shootdown_branch_tag != '0) && (shootdown_branch_tag <= TB'(MAX_PREDICT_DEPTH));
        ck_tag_ok = (s1_ckpt_tag_q != '0) && (s1_ckpt_tag_q <= TB'(MAX_PREDICT_DEPTH));
        sd_idx    = CB'(shootdown_branch_tag - TB'(1));
        ck_idx    = CB'(s1_ckpt_tag_q - TB'(1));
        map_d     = map_q;
        ckpt_d    = ckpt_q;
        if (branch_shootdown) begin
            if (sd_tag_ok) map_d = ckpt_q[sd_idx];
        end else if (fire) begin
            if (s1_has_dst_q[0]) map_d[dst0] = '{mapped: 1'b1, preg: pdst0};
            if (s1_has_dst_q[1]) map_d[dst1] = '{mapped: 1'b1, preg: pdst1};
            if (s1_ckpt_valid_q && ck_tag_ok) ckpt_d[ck_idx] = map_d;
        end
    end

    always_comb begin
        s1_valid_d      = s1_valid_q;
        s1_count_d      = s1_count_q;
        s1_srca_d       = s1_srca_q;
        s1_srcb_d       = s1_srcb_q;
        s1_dst_d        = s1_dst_q;
        s1_has_dst_d    = s1_has_dst_q;
        s1_ckpt_valid_d = s1_ckpt_valid_q;
        s1_ckpt_tag_d   = s1_ckpt_tag_q;
        if (branch_shootdown) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d      = 1'b1;
            s1_count_d      = in_count;
            s1_srca_d       = in_srca;
            s1_srcb_d       = in_srcb;
            s1_dst_d        = in_dst;
            s1_has_dst_d    = in_dst_live;
            s1_ckpt_valid_d = in_ckpt_valid;
            s1_ckpt_tag_d   = in_ckpt_tag;
        end else if (fire) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q      <= 1'b0;
            s1_count_q      <= '0;
            s1_srca_q       <= '0;
            s1_srcb_q       <= '0;
            s1_dst_q        <= '0;
            s1_has_dst_q    <= '0;
            s1_ckpt_valid_q <= 1'b0;
            s1_ckpt_tag_q   <= '0;
            for (int a = 0; a < NUM_AREGS; a++) begin
                map_q[a] <= '0;
                for (int c = 0; c < MAX_PREDICT_DEPTH; c++) ckpt_q[c][a] <= '0;
            end
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_count_q      <= s1_count_d;
            s1_srca_q       <= s1_srca_d;
            s1_srcb_q       <= s1_srcb_d;
            s1_dst_q        <= s1_dst_d;
            s1_has_dst_q    <= s1_has_dst_d;
            s1_ckpt_valid_q <= s1_ckpt_valid_d;
            s1_ckpt_tag_q   <= s1_ckpt_tag_d;
            map_q           <= map_d;
            ckpt_q          <= ckpt_d;
        end
    end

endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: freelist responses are driven by hand the cycle after each pull.
module tb_rename_map;
    localparam int AB = 4;
    localparam int PB = 6;
    localparam int TB = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_count;
    logic [2*AB-1:0] in_srca, in_srcb, in_dst;
    logic [1:0]      in_has_dst;
    logic [2*TB-1:0] in_spec_tag;
    logic            in_ckpt_valid;
    logic [TB-1:0]   in_ckpt_tag;
    logic [1:0]      fl_num_pull;
    logic [TB-1:0]   fl_branch_tag_1, fl_branch_tag_2;
    logic [PB-1:0]   fl_preg1, fl_preg2;
    logic [PB:0]     fl_num_free;
    logic            branch_shootdown;
    logic [TB-1:0]   shootdown_branch_tag;
    logic            out_valid, out_ready;
    logic [1:0]      out_count;
    logic [2*PB-1:0] out_psrca, out_psrcb, out_pdst, out_old_pdst;
    logic [1:0]      out_srca_mapped, out_srcb_mapped, out_old_mapped, out_has_dst;

    int pass_count = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    rename_map dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .in_srca(in_srca), .in_srcb(in_srcb), .in_dst(in_dst), .in_has_dst(in_has_dst),
        .in_spec_tag(in_spec_tag), .in_ckpt_valid(in_ckpt_valid), .in_ckpt_tag(in_ckpt_tag),
        .fl_num_pull(fl_num_pull), .fl_branch_tag_1(fl_branch_tag_1), .fl_branch_tag_2(fl_branch_tag_2),
        .fl_preg1(fl_preg1), .fl_preg2(fl_preg2), .fl_num_free(fl_num_free),
        .branch_shootdown(branch_shootdown), .shootdown_branch_tag(shootdown_branch_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_psrca(out_psrca), .out_psrcb(out_psrcb),
        .out_srca_mapped(out_srca_mapped), .out_srcb_mapped(out_srcb_mapped),
        .out_pdst(out_pdst), .out_old_pdst(out_old_pdst),
        .out_old_mapped(out_old_mapped), .out_has_dst(out_has_dst)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_group(input logic [1:0] cnt, input logic [2*AB-1:0] sa, input logic [2*AB-1:0] sb,
                               input logic [2*AB-1:0] d, input logic [1:0] hd, input logic [2*TB-1:0] tg,
                               input logic ckv, input logic [TB-1:0] ckt);
        in_count      = cnt;
        in_srca       = sa;
        in_srcb       = sb;
        in_dst        = d;
        in_has_dst    = hd;
        in_spec_tag   = tg;
        in_ckpt_valid = ckv;
        in_ckpt_tag   = ckt;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1;
        apply_group(2'd1, '0, '0, {4'd0, 4'd1}, 2'b01, '0, 1'b0, '0);
        step; step;
        check_count++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_count++;
        check_count++; if (fl_num_pull !== 2'd0) $display("FAIL reset_pull got=%0d exp=0", fl_num_pull); else pass_count++;
        check_count++; if (fl_branch_tag_1 !== 3'd0) $display("FAIL reset_tag1 got=%0d exp=0", fl_branch_tag_1); else pass_count++;
        check_count++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_count++;
        check_count++; if (out_pdst !== '0) $display("FAIL reset_pdst got=%h exp=0", out_pdst); else pass_count++;
        reset = 1'b0;
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_single;
        apply_group(2'd1, {4'd0, 4'd2}, {4'd0, 4'd3}, {4'd0, 4'd1}, 2'b01, '0, 1'b0, '0);
        in_valid = 1'b1;
        #1;
        check_count++; if (in_ready !== 1'b1) $display("FAIL single_ready got=%b exp=1", in_ready); else pass_count++;
        check_count++; if (fl_num_pull !== 2'd1) $display("FAIL single_pull got=%0d exp=1", fl_num_pull); else pass_count++;
        step;
        in_valid = 1'b0;
        fl_preg1 = 6'd5;
        #1;
        check_count++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got=%b exp=1", out_valid); else pass_count++;
        check_count++; if (out_count !== 2'd1) $display("FAIL single_count got=%0d exp=1", out_count); else pass_count++;
        check_count++; if ({out_srca_mapped, out_srcb_mapped} !== 4'b0000) $display("FAIL single_src_mapped got=%b exp=0000", {out_srca_mapped, out_srcb_mapped}); else pass_count++;
        check_count++; if (out_pdst !== {6'd0, 6'd5}) $display("FAIL single_pdst got=%h exp=%h", out_pdst, {6'd0, 6'd5}); else pass_count++;
        check_count++; if (out_old_mapped !== 2'b00) $display("FAIL single_old_mapped got=%b exp=00", out_old_mapped); else pass_count++;
        check_count++; if (out_has_dst !== 2'b01) $display("FAIL single_has_dst got=%b exp=01", out_has_dst); else pass_count++;
        step;
        check_count++; if (out_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", out_valid); else pass_count++;
    endtask

    task automatic test_two_wide_bypass;
        apply_group(2'd2, {4'd4, 4'd1}, {4'd1, 4'd0}, {4'd4, 4'd4}, 2'b11, {3'd2, 3'd1}, 1'b0, '0);
        in_valid = 1'b1;
        #1;
        check_count++; if (fl_num_pull !== 2'd2) $display("FAIL two_pull got=%0d exp=2", fl_num_pull); else pass_count++;
        check_count++; if ({fl_branch_tag_2, fl_branch_tag_1} !== {3'd2, 3'd1}) $display("FAIL two_tags got=%0d,%0d exp=2,1", fl_branch_tag_2, fl_branch_tag_1); else pass_count++;
        step;
        apply_group(2'd1, {4'd0, 4'd4}, {4'd0, 4'd1}, '0, 2'b00, '0, 1'b0, '0);
        fl_preg1 = 6'd6;
        fl_preg2 = 6'd7;
        #1;
        check_count++; if (out_psrca !== {6'd6, 6'd5}) $display("FAIL two_psrca got=%h exp=%h", out_psrca, {6'd6, 6'd5}); else pass_count++;
        check_count++; if (out_srca_mapped !== 2'b11) $display("FAIL two_srca_mapped got=%b exp=11", out_srca_mapped); else pass_count++;
        check_count++; if (out_psrcb !== {6'd5, 6'd0}) $display("FAIL two_psrcb got=%h exp=%h", out_psrcb, {6'd5, 6'd0}); else pass_count++;
        check_count++; if (out_srcb_mapped !== 2'b10) $display("FAIL two_srcb_mapped got=%b exp=10", out_srcb_mapped); else pass_count++;
        check_count++; if (out_pdst !== {6'd7, 6'd6}) $display("FAIL two_pdst got=%h exp=%h", out_pdst, {6'd7, 6'd6}); else pass_count++;
        check_count++; if (out_old_pdst !== {6'd6, 6'd0}) $display("FAIL two_old_pdst got=%h exp=%h", out_old_pdst, {6'd6, 6'd0}); else pass_count++;
        check_count++; if (out_old_mapped !== 2'b10) $display("FAIL two_old_mapped got=%b exp=10", out_old_mapped); else pass_count++;
        check_count++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", in_ready); else pass_count++;
        check_count++; if (fl_num_pull !== 2'd0) $display("FAIL need0_pull got=%0d exp=0", fl_num_pull); else pass_count++;
        step;
        in_valid = 1'b0;
        #1;
        check_count++; if (out_valid !== 1'b1) $display("FAIL need0_occupies got=%b exp=1", out_valid); else pass_count++;
        check_count++; if ({out_srca_mapped[0], out_psrca[PB-1:0]} !== {1'b1, 6'd7}) $display("FAIL map_r4_after_fire got=%b/%0d exp=1/7", out_srca_mapped[0], out_psrca[PB-1:0]); else pass_count++;
        check_count++; if (out_psrcb[PB-1:0] !== 6'd5) $display("FAIL map_r1_kept got=%0d exp=5", out_psrcb[PB-1:0]); else pass_count++;
        check_count++; if (out_has_dst !== 2'b00) $display("FAIL need0_has_dst got=%b exp=00", out_has_dst); else pass_count++;
        step;
    endtask

    task automatic test_slot1_only;
        apply_group(2'd2, '0, '0, {4'd8, 4'd0}, 2'b10, {3'd3, 3'd1}, 1'b0, '0);
        in_valid = 1'b1;
        #1;
        check_count++; if (fl_num_pull !== 2'd1) $display("FAIL slot1_pull got=%0d exp=1", fl_num_pull); else pass_count++;
        check_count++; if ({fl_branch_tag_1, fl_branch_tag_2} !== {3'd3, 3'd0}) $display("FAIL slot1_tags got=%0d,%0d exp=3,0", fl_branch_tag_1, fl_branch_tag_2); else pass_count++;
        step;
        in_valid = 1'b0;
        fl_preg1 = 6'd18;
        fl_preg2 = 6'd33;
        #1;
        check_count++; if (out_pdst !== {6'd18, 6'd0}) $display("FAIL slot1_pdst got=%h exp=%h", out_pdst, {6'd18, 6'd0}); else pass_count++;
        check_count++; if (out_has_dst !== 2'b10) $display("FAIL slot1_has_dst got=%b exp=10", out_has_dst); else pass_count++;
        step;
    endtask

    task automatic test_free_count_and_stall;
        fl_num_free = 7'd1;
        apply_group(2'd2, '0, '0, {4'd6, 4'd5}, 2'b11, '0, 1'b0, '0);
        in_valid = 1'b1;
        #1;
        check_count++; if (in_ready !== 1'b0) $display("FAIL free1_ready got=%b exp=0", in_ready); else pass_count++;
        check_count++; if (fl_num_pull !== 2'd0) $display("FAIL free1_pull got=%0d exp=0", fl_num_pull); else pass_count++;
        fl_num_free = 7'd2;
        #1;
        check_count++; if (in_ready !== 1'b1) $display("FAIL free2_ready got=%b exp=1", in_ready); else pass_count++;
        check_count++; if (fl_num_pull !== 2'd2) $display("FAIL free2_pull got=%0d exp=2", fl_num_pull); else pass_count++;
        step;
        out_ready = 1'b0;
        fl_preg1 = 6'd8;
        fl_preg2 = 6'd9;
        fl_num_free = 7'd64;
        apply_group(2'd1, {4'd0, 4'd5}, '0, {4'd0, 4'd7}, 2'b01, '0, 1'b0, '0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_count++; if (out_valid !== 1'b1) $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, out_valid); else pass_count++;
            check_count++; if (out_pdst !== {6'd9, 6'd8}) $display("FAIL stall_pdst cyc=%0d got=%h exp=%h", i, out_pdst, {6'd9, 6'd8}); else pass_count++;
            check_count++; if (fl_num_pull !== 2'd0) $display("FAIL stall_pull cyc=%0d got=%0d exp=0", i, fl_num_pull); else pass_count++;
            check_count++; if (in_ready !== 1'b0) $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, in_ready); else pass_count++;
            step;
        end
        out_ready = 1'b1;
        #1;
        check_count++; if (fl_num_pull !== 2'd1) $display("FAIL unstall_pull got=%0d exp=1", fl_num_pull); else pass_count++;
        step;
        in_valid = 1'b0;
        fl_preg1 = 6'd10;
        #1;
        check_count++; if ({out_srca_mapped[0], out_psrca[PB-1:0]} !== {1'b1, 6'd8}) $display("FAIL stall_map_r5 got=%b/%0d exp=1/8", out_srca_mapped[0], out_psrca[PB-1:0]); else pass_count++;
        check_count++; if (out_pdst[PB-1:0] !== 6'd10) $display("FAIL stall_next_pdst got=%0d exp=10", out_pdst[PB-1:0]); else pass_count++;
        step;
    endtask

    task automatic test_checkpoint_restore;
        apply_group(2'd1, {4'd0, 4'd1}, '0, {4'd0, 4'd3}, 2'b01, '0, 1'b1, 3'd1);
        in_valid = 1'b1;
        step;
        fl_preg1 = 6'd11;
        apply_group(2'd1, '0, '0, {4'd0, 4'd1}, 2'b01, '0, 1'b0, '0);
        step;
        fl_preg1 = 6'd12;
        apply_group(2'd1, {4'd0, 4'd1}, '0, {4'd0, 4'd2}, 2'b01, '0, 1'b0, '0);
        step;
        fl_preg1 = 6'd13;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check_count++; if ({out_srca_mapped[0], out_psrca[PB-1:0]} !== {1'b1, 6'd12}) $display("FAIL ckpt_renamed_r1 got=%b/%0d exp=1/12", out_srca_mapped[0], out_psrca[PB-1:0]); else pass_count++;
        apply_group(2'd1, {4'd0, 4'd1}, {4'd0, 4'd3}, '0, 2'b00, '0, 1'b0, '0);
        in_valid = 1'b1;
        branch_shootdown = 1'b1;
        shootdown_branch_tag = 3'd1;
        #1;
        check_count++; if (in_ready !== 1'b0) $display("FAIL sd_ready got=%b exp=0", in_ready); else pass_count++;
        check_count++; if (fl_num_pull !== 2'd0) $display("FAIL sd_pull got=%0d exp=0", fl_num_pull); else pass_count++;
        step;
        branch_shootdown = 1'b0;
        out_ready = 1'b1;
        #1;
        check_count++; if (out_valid !== 1'b0) $display("FAIL sd_s1_empty got=%b exp=0", out_valid); else pass_count++;
        step;
        in_valid = 1'b0;
        #1;
        check_count++; if ({out_srca_mapped[0], out_psrca[PB-1:0]} !== {1'b1, 6'd5}) $display("FAIL sd_restore_r1 got=%b/%0d exp=1/5", out_srca_mapped[0], out_psrca[PB-1:0]); else pass_count++;
        check_count++; if ({out_srcb_mapped[0], out_psrcb[PB-1:0]} !== {1'b1, 6'd11}) $display("FAIL sd_restore_r3 got=%b/%0d exp=1/11", out_srcb_mapped[0], out_psrcb[PB-1:0]); else pass_count++;
        step;
    endtask

    task automatic test_same_tag_shootdown;
        apply_group(2'd1, '0, '0, {4'd0, 4'd6}, 2'b01, '0, 1'b1, 3'd2);
        in_valid = 1'b1;
        step;
        fl_preg1 = 6'd14;
        apply_group(2'd1, '0, '0, {4'd0, 4'd6}, 2'b01, '0, 1'b1, 3'd2);
        step;
        fl_preg1 = 6'd15;
        in_valid = 1'b0;
        branch_shootdown = 1'b1;
        shootdown_branch_tag = 3'd2;
        step;
        branch_shootdown = 1'b0;
        apply_group(2'd1, {4'd0, 4'd6}, '0, {4'd0, 4'd6}, 2'b01, '0, 1'b0, '0);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        fl_preg1 = 6'd16;
        #1;
        check_count++; if ({out_srca_mapped[0], out_psrca[PB-1:0]} !== {1'b1, 6'd14}) $display("FAIL same_tag_restore got=%b/%0d exp=1/14", out_srca_mapped[0], out_psrca[PB-1:0]); else pass_count++;
        step;
        branch_shootdown = 1'b1;
        shootdown_branch_tag = 3'd2;
        step;
        branch_shootdown = 1'b0;
        apply_group(2'd1, {4'd0, 4'd6}, '0, '0, 2'b00, '0, 1'b0, '0);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        #1;
        check_count++; if ({out_srca_mapped[0], out_psrca[PB-1:0]} !== {1'b1, 6'd14}) $display("FAIL same_tag_write_discarded got=%b/%0d exp=1/14", out_srca_mapped[0], out_psrca[PB-1:0]); else pass_count++;
        step;
    endtask

    task automatic test_reset_mid_stall;
        apply_group(2'd1, '0, '0, {4'd0, 4'd7}, 2'b01, '0, 1'b0, '0);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        fl_preg1 = 6'd17;
        out_ready = 1'b0;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check_count++; if (out_valid !== 1'b0) $display("FAIL rst_stall_valid got=%b exp=0", out_valid); else pass_count++;
        apply_group(2'd1, {4'd0, 4'd7}, '0, '0, 2'b00, '0, 1'b0, '0);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        #1;
        check_count++; if (out_srca_mapped[0] !== 1'b0) $display("FAIL rst_stall_r7_unmapped got=%b exp=0", out_srca_mapped[0]); else pass_count++;
        step;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        fl_preg1 = '0;
        fl_preg2 = '0;
        fl_num_free = 7'd64;
        branch_shootdown = 1'b0;
        shootdown_branch_tag = '0;
        apply_group(2'd0, '0, '0, '0, 2'b00, '0, 1'b0, '0);
        test_reset;
        test_single;
        test_two_wide_bypass;
        test_slot1_only;
        test_free_count_and_stall;
        test_checkpoint_restore;
        test_same_tag_shootdown;
        test_reset_mid_stall;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
